// File: rtl/s_box_48_32_seq.sv
// DES S-box substitution (S1..S8), one S-box evaluated per clock cycle.
// Takes a 48-bit key-mixed block and produces the 32-bit block that feeds the P-box.
module s_box_48_32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:48] s_box_48_32_i,
    input  logic        s_box_48_32_i_valid,
    output logic        s_box_48_32_i_ready,
    output logic [1:32] s_box_48_32_o,
    output logic        s_box_48_32_o_valid,
    input  logic        s_box_48_32_o_ready
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // i_ready is 1 only in IDLE; o_valid is 1 only in DONE and the output holds until o_ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [1:48] r_data;
    logic [1:32] r_out;

    logic [5:0]  w_chunk;
    logic [1:0]  w_row;
    logic [3:0]  w_col;
    logic [63:0] w_row_bits;
    logic [3:0]  w_nib;

    // One table row (16 nibbles, column 0 in the top nibble) selected by box*4 + row.
    function automatic logic [63:0] sbox_row(input logic [2:0] box, input logic [1:0] row);
        sbox_row = 64'h0;
        case ({box, row})
            5'd0:  sbox_row = 64'hE4D12FB83A6C5907;
            5'd1:  sbox_row = 64'h0F74E2D1A6CB9538;
            5'd2:  sbox_row = 64'h41E8D62BFC973A50;
            5'd3:  sbox_row = 64'hFC8249175B3EA06D;
            5'd4:  sbox_row = 64'hF18E6B34972DC05A;
            5'd5:  sbox_row = 64'h3D47F28EC01A69B5;
            5'd6:  sbox_row = 64'h0E7BA4D158C6932F;
            5'd7:  sbox_row = 64'hD8A13F42B67C05E9;
            5'd8:  sbox_row = 64'hA09E63F51DC7B428;
            5'd9:  sbox_row = 64'hD70934A6285ECBF1;
            5'd10: sbox_row = 64'hD6498F30B12C5AE7;
            5'd11: sbox_row = 64'h1AD069874FE3B52C;
            5'd12: sbox_row = 64'h7DE3069A1285BC4F;
            5'd13: sbox_row = 64'hD8B56F03472C1AE9;
            5'd14: sbox_row = 64'hA690CB7DF13E5284;
            5'd15: sbox_row = 64'h3F06A1D8945BC72E;
            5'd16: sbox_row = 64'h2C417AB6853FD0E9;
            5'd17: sbox_row = 64'hEB2C47D150FA3986;
            5'd18: sbox_row = 64'h421BAD78F9C5630E;
            5'd19: sbox_row = 64'hB8C71E2D6F09A453;
            5'd20: sbox_row = 64'hC1AF92680D34E75B;
            5'd21: sbox_row = 64'hAF427C9561DE0B38;
            5'd22: sbox_row = 64'h9EF528C3704A1DB6;
            5'd23: sbox_row = 64'h432C95FABE17608D;
            5'd24: sbox_row = 64'h4B2EF08D3C975A61;
            5'd25: sbox_row = 64'hD0B7491AE35C2F86;
            5'd26: sbox_row = 64'h14BDC37EAF680592;
            5'd27: sbox_row = 64'h6BD814A7950FE23C;
            5'd28: sbox_row = 64'hD2846FB1A93E50C7;
            5'd29: sbox_row = 64'h1FD8A374C56B0E92;
            5'd30: sbox_row = 64'h7B4192CE06ADF358;
            5'd31: sbox_row = 64'h21E74A8DFC90356B;
            default: sbox_row = 64'h0;
        endcase
    endfunction

    always_comb begin
        w_chunk = r_data[1:6];
        case (r_cnt)
            3'd0: w_chunk = r_data[1:6];
            3'd1: w_chunk = r_data[7:12];
            3'd2: w_chunk = r_data[13:18];
            3'd3: w_chunk = r_data[19:24];
            3'd4: w_chunk = r_data[25:30];
            3'd5: w_chunk = r_data[31:36];
            3'd6: w_chunk = r_data[37:42];
            3'd7: w_chunk = r_data[43:48];
            default: w_chunk = r_data[1:6];
        endcase
    end

    // Row comes from the outer chunk bits, column from the inner four.
    assign w_row      = {w_chunk[5], w_chunk[0]};
    assign w_col      = w_chunk[4:1];
    assign w_row_bits = sbox_row(r_cnt, w_row);
    assign w_nib      = w_row_bits[{~w_col, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        s_box_48_32_i_ready = 1'b0;
        s_box_48_32_o_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_box_48_32_i_ready = 1'b1;
                if (s_box_48_32_i_valid) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                s_box_48_32_o_valid = 1'b1;
                if (s_box_48_32_o_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_data <= 48'h0;
            r_out  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_box_48_32_i_valid) begin
                        r_data <= s_box_48_32_i;
                        r_cnt  <= 3'd0;
                    end
                end
                ST_BUSY: begin
                    // Counter wraps 7 -> 0 on the edge that enters DONE.
                    r_cnt <= r_cnt + 3'd1;
                    case (r_cnt)
                        3'd0: r_out[1:4]   <= w_nib;
                        3'd1: r_out[5:8]   <= w_nib;
                        3'd2: r_out[9:12]  <= w_nib;
                        3'd3: r_out[13:16] <= w_nib;
                        3'd4: r_out[17:20] <= w_nib;
                        3'd5: r_out[21:24] <= w_nib;
                        3'd6: r_out[25:28] <= w_nib;
                        3'd7: r_out[29:32] <= w_nib;
                        default: r_out[1:4] <= w_nib;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign s_box_48_32_o = r_out;

endmodule

// File: tb/tb_s_box_48_32_seq.sv
// Self-checking bench for s_box_48_32_seq: reference DES S-box model feeding an expected queue.
`timescale 1ns/1ps
module tb_s_box_48_32_seq;

    logic        clk;
    logic        rst;
    logic [1:48] s_box_48_32_i;
    logic        s_box_48_32_i_valid;
    logic        s_box_48_32_i_ready;
    logic [1:32] s_box_48_32_o;
    logic        s_box_48_32_o_valid;
    logic        s_box_48_32_o_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    s_box_48_32_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_box_48_32_i       (s_box_48_32_i),
        .s_box_48_32_i_valid (s_box_48_32_i_valid),
        .s_box_48_32_i_ready (s_box_48_32_i_ready),
        .s_box_48_32_o       (s_box_48_32_o),
        .s_box_48_32_o_valid (s_box_48_32_o_valid),
        .s_box_48_32_o_ready (s_box_48_32_o_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full FIPS 46-3 tables, one 64-entry box per word, entry (row*16+col) in nibble order from the top.
    logic [255:0] sbox_tbl [0:7];
    initial begin
        sbox_tbl[0] = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
        sbox_tbl[1] = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
        sbox_tbl[2] = 256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
        sbox_tbl[3] = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
        sbox_tbl[4] = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
        sbox_tbl[5] = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
        sbox_tbl[6] = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
        sbox_tbl[7] = 256'hD2846FB1A93E50C71FD8A374C56B0E927B4192CE06ADF35821E74A8DFC90356B;
    end

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0]  r;
        logic [5:0]   c;
        logic [255:0] t;
        int           idx;
        r = 32'h0;
        for (int b = 0; b < 8; b++) begin
            c   = d[47 - 6*b -: 6];
            idx = {c[5], c[0]} * 16 + c[4:1];
            t   = sbox_tbl[b];
            r[31 - 4*b -: 4] = t[255 - 4*idx -: 4];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called #1 after an edge with the DUT in IDLE; returns #1 after the accept edge.
    task automatic drive_block(input logic [47:0] d);
        s_box_48_32_i       = d;
        s_box_48_32_i_valid = 1'b1;
        exp_q.push_back(model(d));
        @(posedge clk);
        #1;
        s_box_48_32_i_valid = 1'b0;
    endtask

    // Counts edges until o_valid is seen (0 if the budget runs out).
    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (s_box_48_32_o_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        s_box_48_32_i = '0;
        s_box_48_32_i_valid = 1'b0;
        s_box_48_32_o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_box_48_32_i_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_i_ready: got %b want 1", s_box_48_32_i_ready);
        end
        n_checks++;
        if (s_box_48_32_o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_o_valid: got %b want 0", s_box_48_32_o_valid);
        end
        n_checks++;
        if (s_box_48_32_o !== 32'h00000000) begin
            n_fail++; $display("FAIL reset_o: got %h want 00000000", s_box_48_32_o);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Accept one block, check latency, result against the queue and a known constant, then IDLE.
    task automatic test_known(input string name, input logic [47:0] d, input logic [31:0] known);
        int lat;
        logic [31:0] exp;
        s_box_48_32_o_ready = 1'b1;
        drive_block(d);
        wait_out(20, lat);
        n_checks++;
        if (lat != 8) begin
            n_fail++; $display("FAIL %s_latency: got %0d edges want 8", name, lat);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (s_box_48_32_o !== exp) begin
            n_fail++; $display("FAIL %s_model: got %h want %h", name, s_box_48_32_o, exp);
        end
        n_checks++;
        if (s_box_48_32_o !== known) begin
            n_fail++; $display("FAIL %s_known: got %h want %h", name, s_box_48_32_o, known);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (s_box_48_32_i_ready !== 1'b1 || s_box_48_32_o_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: got i_ready=%b o_valid=%b want 1/0", name,
                               s_box_48_32_i_ready, s_box_48_32_o_valid);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [63:0] rnd;
        logic [31:0] exp;
        s_box_48_32_o_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            rnd = {$urandom(), $urandom()};
            drive_block(rnd[47:0]);
            wait_out(20, lat);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat != 8 || s_box_48_32_o !== exp) begin
                n_fail++; $display("FAIL random_%0d: got %h lat %0d want %h lat 8", n, s_box_48_32_o, lat, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // o_ready held low while new data is thrown at the input in BUSY and DONE.
    task automatic test_backpressure;
        int lat;
        int bad;
        logic [31:0] held;
        logic [31:0] exp;
        s_box_48_32_o_ready = 1'b0;
        drive_block(48'h123456789ABC);
        s_box_48_32_i       = 48'hFEDCBA987654;
        s_box_48_32_i_valid = 1'b1;
        wait_out(20, lat);
        n_checks++;
        if (lat != 8) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 8", lat);
        end
        held = s_box_48_32_o;
        bad  = 0;
        for (int k = 0; k < 20; k++) begin
            s_box_48_32_i       = {$urandom(), 16'(k)};
            s_box_48_32_i_valid = k[0];
            @(posedge clk);
            #1;
            if (s_box_48_32_o !== held || s_box_48_32_o_valid !== 1'b1 || s_box_48_32_i_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        s_box_48_32_i_valid = 1'b0;
        s_box_48_32_o_ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (s_box_48_32_o !== exp) begin
            n_fail++; $display("FAIL bp_result: got %h want %h", s_box_48_32_o, exp);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (s_box_48_32_i_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got i_ready=%b want 1", s_box_48_32_i_ready);
        end
    endtask

    task automatic test_reset_in_flight;
        int lat;
        int stale;
        s_box_48_32_o_ready = 1'b1;
        drive_block(48'h0F0F0F0F0F0F);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (s_box_48_32_i_ready !== 1'b1 || s_box_48_32_o_valid !== 1'b0 || s_box_48_32_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_busy_async: got i_ready=%b o_valid=%b o=%h want 1/0/00000000",
                               s_box_48_32_i_ready, s_box_48_32_o_valid, s_box_48_32_o);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (s_box_48_32_o_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++; $display("FAIL rst_busy_stale: got %0d o_valid cycles want 0", stale);
        end
        test_known("after_rst", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);

        // Reset while a result waits in DONE.
        s_box_48_32_o_ready = 1'b0;
        drive_block(48'hA5A5A5A5A5A5);
        wait_out(20, lat);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_q.delete();
        s_box_48_32_o_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (s_box_48_32_o_valid) stale++;
        end
        n_checks++;
        if (lat != 8 || stale != 0) begin
            n_fail++; $display("FAIL rst_done: got lat %0d stale %0d want 8/0", lat, stale);
        end
    endtask

    // Two blocks offered continuously with o_ready=1; accepts must be 10 cycles apart.
    task automatic test_back_to_back;
        logic [47:0] blk [2];
        int acc_cyc [2];
        int n_acc;
        int n_out;
        logic acc;
        logic [31:0] exp;
        blk[0] = 48'h3C5A96E1F00F;
        blk[1] = 48'hC3A5691E0FF0;
        n_acc = 0;
        n_out = 0;
        s_box_48_32_o_ready = 1'b1;
        s_box_48_32_i       = blk[0];
        s_box_48_32_i_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
            acc = s_box_48_32_i_ready && s_box_48_32_i_valid;
            if (s_box_48_32_o_valid && s_box_48_32_o_ready) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
                n_checks++;
                if (s_box_48_32_o !== exp) begin
                    n_fail++; $display("FAIL b2b_out%0d: got %h want %h", n_out, s_box_48_32_o, exp);
                end
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(model(blk[n_acc]));
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 2) s_box_48_32_i = blk[n_acc];
                else s_box_48_32_i_valid = 1'b0;
            end
        end
        s_box_48_32_i_valid = 1'b0;
        n_checks++;
        if (n_acc != 2 || n_out != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d accepts %0d outputs want 2/2", n_acc, n_out);
        end else begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 10) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 10", acc_cyc[1] - acc_cyc[0]);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_known("zero", 48'h000000000000, 32'hEFA72C4D);
        test_known("ones", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        test_known("chunk1", 48'h6C0000000000, 32'h5FA72C4D);
        test_random();
        test_backpressure();
        test_reset_in_flight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/s_box_48_32_seq.md
S_BOX_48_32_SEQ -- requirements
Module: s_box_48_32_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports listed clock and reset first.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 s_box_48_32_i  input  [1:48]  key-mixed expansion block; bit 1 is the MSB, DES numbering.
REQ-005 s_box_48_32_i_valid  input  1  input block present.
REQ-006 s_box_48_32_i_ready  output  1  module can accept an input block.
REQ-007 s_box_48_32_o  output  [1:32]  substituted block, bit 1 is the MSB; feeds the 32-bit P-box permutation stage.
REQ-008 s_box_48_32_o_valid  output  1  output block valid.
REQ-009 s_box_48_32_o_ready  input  1  downstream accepts the output block.

Function
REQ-010 The module SHALL implement the eight standard DES S-boxes S1..S8 (FIPS 46-3), evaluated one S-box per clock cycle.
REQ-011 The FSM SHALL have three states:
- IDLE: s_box_48_32_i_ready=1.
- BUSY: substitution in progress.
- DONE: s_box_48_32_o_valid=1.
REQ-012 s_box_48_32_i_ready SHALL be 1 only in IDLE; s_box_48_32_o_valid SHALL be 1 only in DONE.
REQ-013 Accept: in IDLE with s_box_48_32_i_valid=1, the module SHALL, on that edge:
- capture s_box_48_32_i into an internal 48-bit register;
- clear a 3-bit counter cnt to 0;
- enter BUSY.
REQ-014 In BUSY, on each edge, the module SHALL:
- take chunk bits 6*cnt+1..6*cnt+6 of the captured input;
- substitute the chunk through S(cnt+1);
- write the 4-bit result into output-register bits 4*cnt+1..4*cnt+4.
REQ-015 Indexing within each chunk c1..c6 SHALL be: row = {c1,c6}, column = {c2,c3,c4,c5}; the result is 4 bits, MSB first.
REQ-016 Counter and state transitions in BUSY:
- cnt < 7: cnt SHALL increment.
- cnt = 7: the FSM SHALL enter DONE and cnt SHALL wrap to 0.
REQ-017 Latency SHALL be exactly 8 cycles: o_valid rises on the 8th rising edge after the accept edge.
REQ-018 In DONE, s_box_48_32_o SHALL be held stable until s_box_48_32_o_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-019 Sustained throughput SHALL be one block per 10 cycles when o_ready is held at 1.
REQ-020 s_box_48_32_i and s_box_48_32_i_valid SHALL be ignored in BUSY and DONE, and the captured input SHALL NOT change there.
REQ-021 s_box_48_32_o bits not yet written during BUSY are don't-care; only their value in DONE is specified.
REQ-022 The S-box lookup SHALL be combinational from the selected chunk and cnt; the module SHALL add no other pipeline stage.

Reset
REQ-023 On rst=1, asynchronously and regardless of state, the module SHALL set:
- state = IDLE, cnt = 0;
- captured input = 0;
- s_box_48_32_o = 32'h00000000, s_box_48_32_o_valid = 0, s_box_48_32_i_ready = 1.
REQ-024 Reset asserted mid-BUSY or in DONE SHALL discard the block in flight; no o_valid pulse SHALL follow.
REQ-025 After rst deasserts, the first rising edge with s_box_48_32_i_valid=1 SHALL be an accept edge.

Verification
REQ-026 Input 48'h000000000000, o_ready=1 -> o_valid high 8 edges after accept, s_box_48_32_o=32'hEFA72C4D, back in IDLE one edge later.
REQ-027 Input 48'hFFFFFFFFFFFF -> s_box_48_32_o=32'hD9CE3DCB.
REQ-028 Input with chunk 1 = 6'b011011 and all other chunks zero -> s_box_48_32_o=32'h5FA72C4D (S1 row 1, column 13 = 5).
REQ-029 o_ready held 0 for 20 cycles after DONE while i_valid toggles with new data -> output stable, i_ready=0 throughout, original result delivered when o_ready=1.
REQ-030 rst pulsed at the 4th BUSY cycle, then 48'hFFFFFFFFFFFF applied -> no stale o_valid, result 32'hD9CE3DCB after 8 cycles.
REQ-031 Two blocks streamed with o_ready=1 -> accept edges 10 cycles apart, both results match the reference model.
